// File: rtl/line_sqdiff_sum_gen_if.sv
// Pixel-pair input stream and line-sum output stream between fetch logic,
// the squared-difference line summer and the line-sum accumulator.
interface line_sqdiff_sum_gen_if #(
  parameter int PIXEL_SIZE   = 8,
  parameter int LINE_SIZE    = 640,
  parameter int NUM_OF_LINES = 480
);
  localparam int LSW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int LCW = $clog2(NUM_OF_LINES);

  logic [PIXEL_SIZE-1:0] pix_a;
  logic [PIXEL_SIZE-1:0] pix_b;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [LSW-1:0]        line_sum;
  logic                  line_valid;
  logic                  line_ready;
  logic [LCW-1:0]        line_idx;

  modport master (
    output pix_a, pix_b, pix_valid, line_ready,
    input  pix_ready, line_sum, line_valid, line_idx
  );

  modport slave (
    input  pix_a, pix_b, pix_valid, line_ready,
    output pix_ready, line_sum, line_valid, line_idx
  );
endinterface

// File: rtl/line_sqdiff_sum_gen.sv
// Per-line sum of squared pixel differences, one line_sum per line over valid/ready.
// Optional macro LINE_SUM_PIPE_EN registers the square before accumulation (adds a DRAIN state).
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting pixel pairs, accumulating the line sum
// DRAIN | (LINE_SUM_PIPE_EN only) folds the last registered square into the sum
// SEND  | presenting line_sum until line_ready
// DONE  | one-cycle frame_done pulse
module line_sqdiff_sum_gen #(
  parameter int PIXEL_SIZE   = 8,
  parameter int LINE_SIZE    = 640,
  parameter int NUM_OF_LINES = 480
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  line_sqdiff_sum_gen_if.slave bus,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int LSW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int PCW = $clog2(LINE_SIZE);
  localparam int LCW = $clog2(NUM_OF_LINES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SEND  = 3'd2,
    DONE  = 3'd3
`ifdef LINE_SUM_PIPE_EN
    , DRAIN = 3'd4
`endif
  } state_t;

  state_t state, state_nxt;

  logic [PCW-1:0]          pix_cnt;
  logic [LCW-1:0]          line_idx;
  logic [LSW-1:0]          psum;
  logic [LSW-1:0]          line_sum;
  logic [PIXEL_SIZE-1:0]   diff;
  logic [2*PIXEL_SIZE-1:0] diff_w;
  logic [2*PIXEL_SIZE-1:0] sq;
  logic                    xfer;
  logic                    last_pix;
  logic                    last_line;

  assign xfer      = bus.pix_valid && (state == ACCUM);
  assign last_pix  = (pix_cnt == PCW'(LINE_SIZE - 1));
  assign last_line = (line_idx == LCW'(NUM_OF_LINES - 1));
  assign diff      = (bus.pix_a >= bus.pix_b) ? (bus.pix_a - bus.pix_b) : (bus.pix_b - bus.pix_a);
  assign diff_w    = {{PIXEL_SIZE{1'b0}}, diff};
  assign sq        = diff_w * diff_w;

`ifdef LINE_SUM_PIPE_EN
  logic [2*PIXEL_SIZE-1:0] sq_r;
  logic                    sq_v;
  logic [LSW-1:0]          add_term;
  assign add_term = sq_v ? LSW'(sq_r) : '0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
`ifdef LINE_SUM_PIPE_EN
      ACCUM: if (xfer && last_pix) state_nxt = DRAIN;
      DRAIN: state_nxt = SEND;
`else
      ACCUM: if (xfer && last_pix) state_nxt = SEND;
`endif
      SEND:  if (bus.line_ready) state_nxt = last_line ? DONE : ACCUM;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready  = (state == ACCUM);
    bus.line_valid = (state == SEND);
    busy           = (state != IDLE);
    frame_done     = (state == DONE);
  end

  assign bus.line_sum = line_sum;
  assign bus.line_idx = line_idx;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pix_cnt  <= '0;
      line_idx <= '0;
      psum     <= '0;
      line_sum <= '0;
`ifdef LINE_SUM_PIPE_EN
      sq_r     <= '0;
      sq_v     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          pix_cnt  <= '0;
          line_idx <= '0;
          psum     <= '0;
        end
`ifdef LINE_SUM_PIPE_EN
        ACCUM: begin
          sq_r <= sq;
          sq_v <= xfer;
          psum <= psum + add_term;
          if (xfer) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        end
        DRAIN: begin
          line_sum <= psum + add_term;
          psum     <= '0;
          sq_v     <= 1'b0;
        end
`else
        ACCUM: if (xfer) begin
          if (last_pix) begin
            line_sum <= psum + LSW'(sq);
            psum     <= '0;
            pix_cnt  <= '0;
          end else begin
            psum     <= psum + LSW'(sq);
            pix_cnt  <= pix_cnt + 1'b1;
          end
        end
`endif
        SEND: if (bus.line_ready && !last_line) line_idx <= line_idx + 1'b1;
        DONE: line_idx <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_line_sqdiff_sum_gen.sv
// Directed + randomized bench for line_sqdiff_sum_gen: small (4x2) and full-width (640x2) instances.
module tb_line_sqdiff_sum_gen;
`ifdef LINE_SUM_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic CLK = 1'b0;
  logic reset, start_s, start_l, sel;
  logic [7:0] pix_a, pix_b;
  logic pix_valid, line_ready;
  logic busy_s, busy_l, fd_s, fd_l;
  logic [31:0] obs_sum, obs_idx;
  logic obs_valid, obs_ready, obs_busy, obs_fd;
  int vectors = 0;
  int errors = 0;
  int pa[640];
  int pb[640];

  always #5 CLK = ~CLK;

  line_sqdiff_sum_gen_if #(.PIXEL_SIZE(8), .LINE_SIZE(4), .NUM_OF_LINES(2)) if_s ();
  line_sqdiff_sum_gen_if #(.PIXEL_SIZE(8), .LINE_SIZE(640), .NUM_OF_LINES(2)) if_l ();

  assign if_s.pix_a = pix_a;           assign if_l.pix_a = pix_a;
  assign if_s.pix_b = pix_b;           assign if_l.pix_b = pix_b;
  assign if_s.pix_valid = pix_valid;   assign if_l.pix_valid = pix_valid;
  assign if_s.line_ready = line_ready; assign if_l.line_ready = line_ready;

  line_sqdiff_sum_gen #(.PIXEL_SIZE(8), .LINE_SIZE(4), .NUM_OF_LINES(2)) dut_s (
    .CLK(CLK), .reset(reset), .start(start_s), .bus(if_s.slave), .busy(busy_s), .frame_done(fd_s));
  line_sqdiff_sum_gen #(.PIXEL_SIZE(8), .LINE_SIZE(640), .NUM_OF_LINES(2)) dut_l (
    .CLK(CLK), .reset(reset), .start(start_l), .bus(if_l.slave), .busy(busy_l), .frame_done(fd_l));

  always_comb begin
    obs_sum   = sel ? 32'(if_l.line_sum) : 32'(if_s.line_sum);
    obs_idx   = sel ? 32'(if_l.line_idx) : 32'(if_s.line_idx);
    obs_valid = sel ? if_l.line_valid : if_s.line_valid;
    obs_ready = sel ? if_l.pix_ready : if_s.pix_ready;
    obs_busy  = sel ? busy_l : busy_s;
    obs_fd    = sel ? fd_l : fd_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain integer sum of squared differences over the stored pairs.
  function automatic int ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += (pa[i] - pb[i]) * (pa[i] - pb[i]);
    return s;
  endfunction

  task automatic fill_scen1();
    pa[0] = 10;  pb[0] = 7;
    pa[1] = 0;   pb[1] = 255;
    pa[2] = 5;   pb[2] = 5;
    pa[3] = 200; pb[3] = 100;
  endtask

  task automatic fill_const(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin pa[i] = a; pb[i] = b; end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin pa[i] = int'($urandom_range(255)); pb[i] = int'($urandom_range(255)); end
  endtask

  task automatic start_frame();
    if (sel) start_l = 1'b1; else start_s = 1'b1;
    step();
    start_s = 1'b0;
    start_l = 1'b0;
  endtask

  // Feed n pairs; returns at the first sample after the last transfer edge.
  task automatic feed(input int n, input bit bubbles);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 4000) begin
      pix_valid = bubbles ? ((cyc % 3) == 0) : 1'b1;
      pix_a = 8'(pa[i]);
      pix_b = 8'(pb[i]);
      if (pix_valid && obs_ready) i++;
      step();
      cyc++;
    end
    pix_valid = 1'b0;
    if (i < n) check("feed_timeout", 32'(i), 32'(n));
  endtask

  task automatic expect_line(input string tag, input int exp_sum, input int exp_idx);
    int lat = 1;
    while (!obs_valid && lat < 8) begin step(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
    check({tag, "_sum"}, obs_sum, 32'(exp_sum));
    check({tag, "_idx"}, obs_idx, 32'(exp_idx));
  endtask

  task automatic accept(input string tag, input int hold);
    logic [31:0] held;
    held = obs_sum;
    line_ready = 1'b0;
    pix_valid = 1'b1;
    pix_a = 8'($urandom);
    pix_b = 8'($urandom);
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, "_hold_valid"}, 32'(obs_valid), 32'd1);
      check({tag, "_hold_sum"}, obs_sum, held);
      check({tag, "_hold_pixready"}, 32'(obs_ready), 32'd0);
    end
    pix_valid = 1'b0;
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(obs_valid), 32'd0);
  endtask

  task automatic expect_done(input string tag, input int last_sum);
    check({tag, "_frame_done"}, 32'(obs_fd), 32'd1);
    step();
    check({tag, "_frame_done_off"}, 32'(obs_fd), 32'd0);
    check({tag, "_busy_off"}, 32'(obs_busy), 32'd0);
    check({tag, "_idx_clear"}, obs_idx, 32'd0);
    check({tag, "_sum_hold"}, obs_sum, 32'(last_sum));
  endtask

  initial begin
    int s;
    reset = 1'b1; start_s = 1'b0; start_l = 1'b0; sel = 1'b0;
    pix_a = '0; pix_b = '0; pix_valid = 1'b0; line_ready = 1'b0;
    step(); step();
    check("rst_sum", obs_sum, 32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_pixready", 32'(obs_ready), 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_idx", obs_idx, 32'd0);
    reset = 1'b0;
    step();

    // Frame A: reference data, then an all-zero line.
    start_frame();
    check("a_busy", 32'(obs_busy), 32'd1);
    fill_scen1();
    check("scen1_ref", 32'(ref_sum(4)), 32'd75034);
    feed(4, 1'b0);
    expect_line("a_l0", 75034, 0);
    accept("a_l0", 0);
    fill_const(4, 0, 0);
    feed(4, 1'b0);
    expect_line("a_l1", 0, 1);
    accept("a_l1", 0);
    expect_done("a", 0);

    // Frame B: bubbles on line 0, backpressure while pixels are offered.
    start_frame();
    fill_scen1();
    feed(4, 1'b1);
    expect_line("b_l0", 75034, 0);
    accept("b_l0", 5);
    fill_rand(4);
    s = ref_sum(4);
    feed(4, 1'b0);
    expect_line("b_l1", s, 1);
    accept("b_l1", 2);
    expect_done("b", s);

    // Frame C: reset two pixels into line 1.
    start_frame();
    fill_rand(4);
    feed(4, 1'b0);
    expect_line("c_l0", ref_sum(4), 0);
    accept("c_l0", 0);
    fill_rand(4);
    feed(2, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("arst_sum", obs_sum, 32'd0);
    check("arst_valid", 32'(obs_valid), 32'd0);
    check("arst_pixready", 32'(obs_ready), 32'd0);
    check("arst_busy", 32'(obs_busy), 32'd0);
    check("arst_idx", obs_idx, 32'd0);
    check("arst_fd", 32'(obs_fd), 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    check("post_rst_idle_valid", 32'(obs_valid), 32'd0);

    // Frame D: fresh frame after reset, start held high during accumulation.
    start_frame();
    fill_rand(4);
    s = ref_sum(4);
    start_s = 1'b1;
    feed(4, 1'b0);
    start_s = 1'b0;
    expect_line("d_l0", s, 0);
    accept("d_l0", 0);
    fill_rand(4);
    s = ref_sum(4);
    feed(4, 1'b0);
    expect_line("d_l1", s, 1);
    accept("d_l1", 0);
    expect_done("d", s);

    // Full-width instance: maximum-value line, then a random line.
    sel = 1'b1;
    step();
    start_frame();
    fill_const(640, 255, 0);
    feed(640, 1'b0);
    expect_line("max_l0", 41616000, 0);
    accept("max_l0", 1);
    fill_rand(640);
    s = ref_sum(640);
    feed(640, 1'b1);
    expect_line("max_l1", s, 1);
    accept("max_l1", 0);
    expect_done("max", s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/line_sqdiff_sum_gen.md
Name: line_sqdiff_sum_gen

Overview:
Producer side of the line-sum interface. Streams pixel pairs (reference image, test image) for one frame, computes the per-line sum of squared pixel differences, and presents one line_sum per line over a valid/ready handshake to the downstream line-sum accumulator. Sits between the pixel fetch logic and the accumulator in the MSE/PSNR path. Frame geometry comes from the shared parameter set.

Parameters:
PIXEL_SIZE, 8, bits per pixel sample
LINE_SIZE, 640, pixels per line
NUM_OF_LINES, 480, lines per frame
LSW (localparam), $clog2(LINE_SIZE)+2*PIXEL_SIZE, line_sum width
PCW (localparam), $clog2(LINE_SIZE), pixel counter width
LCW (localparam), $clog2(NUM_OF_LINES), line counter width

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a frame; sampled only in IDLE
pix_a  in  PIXEL_SIZE  reference pixel, unsigned
pix_b  in  PIXEL_SIZE  test pixel, unsigned
pix_valid  in  1  pixel pair valid
pix_ready  out  1  block accepts pixel pair this cycle
line_sum  out  LSW  sum of (pix_a-pix_b)^2 over one line
line_valid  out  1  line_sum valid
line_ready  in  1  downstream accepts line_sum
line_idx  out  LCW  index of line currently accumulated or presented
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last line is accepted

Behaviour:
- Reset (async, active-high): state IDLE; pix_ready=0, line_valid=0, line_sum=0, line_idx=0, busy=0, frame_done=0; pixel counter, line counter, and partial sum cleared. Reset mid-frame discards all partial results. No line is emitted until the next start.
- States: IDLE, ACCUM, SEND, DONE. DRAIN is added only with the optional feature.
- IDLE: pix_ready=0. start=1 moves to ACCUM, with pix_cnt=0, line_idx=0, and partial sum 0.
- ACCUM: pix_ready=1. A transfer occurs when pix_valid&&pix_ready.
  - Per transfer: d = |pix_a-pix_b| (PIXEL_SIZE bits); sq = d*d (2*PIXEL_SIZE bits, unsigned); psum += sq (LSW bits); pix_cnt++.
  - Transfer with pix_cnt==LINE_SIZE-1: line_sum <= psum+sq; psum <= 0; pix_cnt <= 0; next state SEND.
  - Latency: line_valid rises on the cycle after the last pixel transfer.
  - pix_valid=0 stalls with no state change.
- SEND: line_valid=1, pix_ready=0, line_sum held stable until the handshake.
  - On line_ready=1: line_valid drops the next cycle.
  - If line_idx==NUM_OF_LINES-1, go to DONE. Otherwise go to ACCUM with line_idx++.
  - line_valid must never drop without line_ready.
- DONE: frame_done=1 for exactly one cycle, then IDLE with line_idx=0. line_sum keeps the last sent value.
- start is ignored outside IDLE. start held high in IDLE after DONE begins a new frame.
- Width rule: LINE_SIZE*(2^PIXEL_SIZE-1)^2 < 2^LSW, so no overflow is possible. No saturation logic.
- line_sum is never X. It is 0 from reset and holds its last sent value between lines.

Optional Feature:
LINE_SUM_PIPE_EN
- Defined: sq is registered (one pipeline stage) before being added to psum, so pix_ready can stay high at full rate with a shorter critical path.
  - After the last-pixel transfer, the FSM enters DRAIN for one cycle, adds the final registered sq, then enters SEND.
  - line_valid rises 2 cycles after the last pixel transfer.
  - Reset also clears the sq register and its valid bit.
- Undefined: combinational square-and-add as described above; 1-cycle latency; no DRAIN state.

Test Plan:
1. Override LINE_SIZE=4, NUM_OF_LINES=2. Start; line 0 pairs (10,7),(0,255),(5,5),(200,100), line_ready=1. Required: line_sum=9+65025+0+10000=75034, line_idx=0, line_valid 1 cycle after 4th transfer. Line 1 all pairs (0,0): line_sum=0, line_idx=1. frame_done pulses once after the second handshake.
2. Backpressure: hold line_ready=0 for 5 cycles in SEND. Required: line_valid=1 and line_sum constant throughout, pix_ready=0, no pixels consumed. Release: exactly one handshake.
3. Bubbles: pix_valid toggles 1,0,0,1,… with the same data as scenario 1. Required: identical line_sum 75034; pixel count unaffected by idle cycles.
4. Max value: all pairs (255,0), LINE_SIZE=640. Required: line_sum=640*65025=41616000, fits in LSW=26 bits.
5. Reset after 2 pixels of line 1. Required: all outputs return to reset values immediately (async). Next start emits line_idx=0 with a fresh sum.
6. With LINE_SUM_PIPE_EN: rerun scenario 1. Required: same sums; line_valid rises 2 cycles after the last transfer; full-rate pix_ready.
